// File: rtl/router_pkg.sv
// Shared router constants: header TID marker, port direction indices, arbiter states.
// Also holds the modulo helper used by the rotating-priority picker.
package router_pkg;

   localparam logic [3:0] ROUTING_HEADER = 4'hF;

   localparam int DIR_LOCAL = 0;
   localparam int DIR_NORTH = 1;
   localparam int DIR_EAST  = 2;
   localparam int DIR_SOUTH = 3;
   localparam int DIR_WEST  = 4;
   localparam int NUM_DIRS  = 5;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   function automatic int rr_index(input int ptr, input int step, input int n);
      return (ptr + step) % n;
   endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle with mandatory TID/TLAST; TDEST/TUSER appear only when enabled.
interface axis_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
`ifdef TDEST_PRESENT
   , parameter int DEST_WIDTH = 4
`endif
`ifdef TUSER_PRESENT
   , parameter int USER_WIDTH = 4
`endif
);
   logic                  TVALID;
   logic                  TREADY;
   logic [DATA_WIDTH-1:0] TDATA;
   logic [ID_WIDTH-1:0]   TID;
   logic                  TLAST;
`ifdef TDEST_PRESENT
   logic [DEST_WIDTH-1:0] TDEST;
`endif
`ifdef TUSER_PRESENT
   logic [USER_WIDTH-1:0] TUSER;
`endif

   modport m (
      input  TREADY,
      output TVALID, TDATA, TID, TLAST
`ifdef TDEST_PRESENT
      , TDEST
`endif
`ifdef TUSER_PRESENT
      , TUSER
`endif
   );

   modport s (
      output TREADY,
      input  TVALID, TDATA, TID, TLAST
`ifdef TDEST_PRESENT
      , TDEST
`endif
`ifdef TUSER_PRESENT
      , TUSER
`endif
   );

endinterface

// File: rtl/rr_picker.sv
// Combinational rotating-priority select: first requester after ptr_i, wrapping modulo N.
// Zero latency; found_o low and idx_o zero when nothing requests.
module rr_picker
   import router_pkg::*;
#(
   parameter int N = 5,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   int cand;

   // Walk from lowest to highest priority so the closest requester after ptr_i wins.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      cand    = 0;
      for (int k = N; k >= 1; k--) begin
         cand = rr_index(int'(ptr_i), k, N);
         if (req_i[cand]) begin
            idx_o   = W'(cand);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Per-output wormhole arbiter: round-robin grant of whole packets, 1-cycle arbitration, registered output.
// Granted input sees TREADY only while the one-entry output register can take a beat; payload holds while stalled.
module axis_packet_arbiter
   import router_pkg::*;
#(
   parameter int INPUT_NUMBER       = 5,
   parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER),
   parameter int DATA_WIDTH         = 32,
   parameter int ID_WIDTH           = 4
`ifdef TDEST_PRESENT
   , parameter int DEST_WIDTH = 4
`endif
`ifdef TUSER_PRESENT
   , parameter int USER_WIDTH = 4
`endif
) (
   input  logic                          clk,
   input  logic                          rst,
   axis_if.s                             in [INPUT_NUMBER],
   axis_if.m                             out,
   output logic [INPUT_NUMBER_WIDTH-1:0] current_grant,
   output logic                          grant_valid
);

   logic [INPUT_NUMBER-1:0] in_vld;
   logic [INPUT_NUMBER-1:0] in_last;
   logic [INPUT_NUMBER-1:0] in_rdy;
   logic [INPUT_NUMBER-1:0] cand;
   logic [DATA_WIDTH-1:0]   in_dat [INPUT_NUMBER];
   logic [ID_WIDTH-1:0]     in_id  [INPUT_NUMBER];
`ifdef TDEST_PRESENT
   logic [DEST_WIDTH-1:0]   in_dest [INPUT_NUMBER];
   logic [DEST_WIDTH-1:0]   out_dest_q, out_dest_d;
`endif
`ifdef TUSER_PRESENT
   logic [USER_WIDTH-1:0]   in_user [INPUT_NUMBER];
   logic [USER_WIDTH-1:0]   out_user_q, out_user_d;
`endif

   logic [0:0]                    state_q, state_d;
   logic [INPUT_NUMBER_WIDTH-1:0] grant_q, grant_d;
   logic [INPUT_NUMBER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [INPUT_NUMBER_WIDTH-1:0] pick_idx;
   logic                          pick_found;

   logic                  out_vld_q, out_vld_d;
   logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
   logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
   logic                  out_last_q, out_last_d;

   logic sel_vld;
   logic sel_last;
   logic out_free;
   logic accept;

   for (genvar g = 0; g < INPUT_NUMBER; g++) begin : g_in
      assign in_vld[g]    = in[g].TVALID;
      assign in_last[g]   = in[g].TLAST;
      assign in_dat[g]    = in[g].TDATA;
      assign in_id[g]     = in[g].TID;
      assign in[g].TREADY = in_rdy[g];
`ifdef TDEST_PRESENT
      assign in_dest[g]   = in[g].TDEST;
`endif
`ifdef TUSER_PRESENT
      assign in_user[g]   = in[g].TUSER;
`endif
      // Only header beats may open a packet; stray body beats are never granted.
      assign cand[g] = in[g].TVALID && (in[g].TID == ID_WIDTH'(ROUTING_HEADER));
   end

   rr_picker #(
      .N (INPUT_NUMBER),
      .W (INPUT_NUMBER_WIDTH)
   ) u_rr_picker (
      .req_i   (cand),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   assign sel_vld  = in_vld[grant_q];
   assign sel_last = in_last[grant_q];
   assign out_free = !out_vld_q || out.TREADY;
   assign accept   = (state_q == LOCKED) && sel_vld && out_free;

   always_comb begin
      in_rdy = '0;
      if (state_q == LOCKED) begin
         in_rdy[grant_q] = out_free;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      if (state_q == IDLE) begin
         if (pick_found) begin
            state_d = LOCKED;
            grant_d = pick_idx;
         end
      end else if (accept && sel_last) begin
         // Released input becomes lowest priority for the next round.
         state_d  = IDLE;
         grant_d  = '0;
         rr_ptr_d = grant_q;
      end
   end

   always_comb begin
      out_vld_d  = out_vld_q;
      out_dat_d  = out_dat_q;
      out_id_d   = out_id_q;
      out_last_d = out_last_q;
`ifdef TDEST_PRESENT
      out_dest_d = out_dest_q;
`endif
`ifdef TUSER_PRESENT
      out_user_d = out_user_q;
`endif
      if (accept) begin
         out_vld_d  = 1'b1;
         out_dat_d  = in_dat[grant_q];
         out_id_d   = in_id[grant_q];
         out_last_d = sel_last;
`ifdef TDEST_PRESENT
         out_dest_d = in_dest[grant_q];
`endif
`ifdef TUSER_PRESENT
         out_user_d = in_user[grant_q];
`endif
      end else if (out.TREADY) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         out_id_q   <= '0;
         out_last_q <= 1'b0;
`ifdef TDEST_PRESENT
         out_dest_q <= '0;
`endif
`ifdef TUSER_PRESENT
         out_user_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         out_vld_q  <= out_vld_d;
         out_dat_q  <= out_dat_d;
         out_id_q   <= out_id_d;
         out_last_q <= out_last_d;
`ifdef TDEST_PRESENT
         out_dest_q <= out_dest_d;
`endif
`ifdef TUSER_PRESENT
         out_user_q <= out_user_d;
`endif
      end
   end

   assign out.TVALID    = out_vld_q;
   assign out.TDATA     = out_dat_q;
   assign out.TID       = out_id_q;
   assign out.TLAST     = out_last_q;
`ifdef TDEST_PRESENT
   assign out.TDEST     = out_dest_q;
`endif
`ifdef TUSER_PRESENT
   assign out.TUSER     = out_user_q;
`endif
   assign current_grant = grant_q;
   assign grant_valid   = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench: expected beats queued in hand-computed order, checked by an independent output monitor.
module tb_axis_packet_arbiter;
   import router_pkg::*;

   localparam int N  = 5;
   localparam int W  = 3;
   localparam int DW = 32;
   localparam int IW = 4;

   typedef struct packed {
      logic [DW-1:0] dat;
      logic [IW-1:0] id;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic out_rdy;
   logic [N-1:0]  drv_vld;
   logic [N-1:0]  drv_last;
   logic [N-1:0]  drv_rdy;
   logic [DW-1:0] drv_dat [N];
   logic [IW-1:0] drv_id  [N];
   logic [W-1:0]  current_grant;
   logic          grant_valid;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   hs_cyc[$];
   exp_t exp_q[$];
   logic t5_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) in_if [N] ();
   axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) out_if ();

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign in_if[g].TVALID = drv_vld[g];
      assign in_if[g].TDATA  = drv_dat[g];
      assign in_if[g].TID    = drv_id[g];
      assign in_if[g].TLAST  = drv_last[g];
      assign drv_rdy[g]      = in_if[g].TREADY;
   end
   assign out_if.TREADY = out_rdy;

   axis_packet_arbiter #(
      .INPUT_NUMBER       (N),
      .INPUT_NUMBER_WIDTH (W),
      .DATA_WIDTH         (DW),
      .ID_WIDTH           (IW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in            (in_if),
      .out           (out_if),
      .current_grant (current_grant),
      .grant_valid   (grant_valid)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Beat payload encodes source port, test number and beat index.
   function automatic exp_t mk_beat(input int port, input int test, input int b, input int nbeats);
      exp_t e;
      e.dat  = {8'(port), 8'(test), 16'(b)};
      e.id   = (b == 0) ? ROUTING_HEADER : 4'h0;
      e.last = (b == nbeats - 1);
      return e;
   endfunction

   task automatic push_pkt(input int port, input int test, input int nbeats);
      for (int b = 0; b < nbeats; b++) exp_q.push_back(mk_beat(port, test, b, nbeats));
   endtask

   task automatic set_beat(input int port, input exp_t e);
      drv_vld[port]  = 1'b1;
      drv_dat[port]  = e.dat;
      drv_id[port]   = e.id;
      drv_last[port] = e.last;
   endtask

   task automatic wait_accept(input int port);
      logic hs;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         hs = drv_rdy[port];
         @(posedge clk);
         #1;
         if (hs) return;
      end
      fail_timeout($sformatf("accept_port%0d", port));
   endtask

   task automatic send_pkt(input int port, input int test, input int nbeats,
                           input int gap_after, input int gap_len);
      for (int b = 0; b < nbeats; b++) begin
         set_beat(port, mk_beat(port, test, b, nbeats));
         wait_accept(port);
         if (b == gap_after && gap_len > 0) begin
            drv_vld[port] = 1'b0;
            repeat (gap_len) begin
               @(posedge clk);
               #1;
            end
         end
      end
      drv_vld[port] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_if.TVALID) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: pops one expectation per output handshake and guards payload stability under stall.
   initial begin : monitor
      logic prev_stall;
      exp_t prev;
      exp_t e;
      prev_stall = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         if (prev_stall) begin
            check("stall_valid", out_if.TVALID, 1);
            check("stall_data", out_if.TDATA, prev.dat);
            check("stall_last", out_if.TLAST, prev.last);
         end
         if (out_if.TVALID && out_rdy && !rst) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=%0h required=none", out_if.TDATA);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_if.TDATA, e.dat);
               check("out_tid", out_if.TID, e.id);
               check("out_last", out_if.TLAST, e.last);
            end
         end
         prev_stall = out_if.TVALID && !out_rdy && !rst;
         prev.dat   = out_if.TDATA;
         prev.id    = out_if.TID;
         prev.last  = out_if.TLAST;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst     = 1'b1;
      out_rdy = 1'b1;
      drv_vld = '0;
      drv_last = '0;
      t5_done = 1'b0;
      for (int i = 0; i < N; i++) begin
         drv_dat[i] = '0;
         drv_id[i]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_if.TVALID, 0);
      check("rst_grant_valid", grant_valid, 0);
      check("rst_current_grant", current_grant, 0);
      check("rst_tready", drv_rdy, 0);
      @(posedge clk);
      #1;

      // T1: single 3-beat packet on the east branch, full throughput.
      hs_cyc.delete();
      push_pkt(DIR_EAST, 1, 3);
      fork
         send_pkt(DIR_EAST, 1, 3, -1, 0);
         begin
            @(negedge clk);
            check("t1_arb_cycle_gv", grant_valid, 0);
            check("t1_arb_cycle_rdy", drv_rdy[DIR_EAST], 0);
            @(negedge clk);
            check("t1_grant_valid", grant_valid, 1);
            check("t1_grant_idx", current_grant, 2);
         end
      join
      check("t1_release", grant_valid, 0);
      drain();
      check("t1_beat_count", hs_cyc.size(), 3);
      check("t1_consecutive", (hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[0] : -1, 2);

      // T2: three simultaneous headers from fresh reset, then a second round.
      do_reset();
      push_pkt(0, 2, 2);
      push_pkt(1, 2, 2);
      push_pkt(4, 2, 2);
      fork
         send_pkt(4, 2, 2, -1, 0);
         send_pkt(1, 2, 2, -1, 0);
         send_pkt(0, 2, 2, -1, 0);
      join
      drain();
      push_pkt(0, 3, 2);
      push_pkt(4, 3, 2);
      fork
         send_pkt(4, 3, 2, -1, 0);
         send_pkt(0, 3, 2, -1, 0);
      join
      drain();

      // T3: output stalls four cycles mid-packet.
      push_pkt(1, 4, 4);
      fork
         send_pkt(1, 4, 4, -1, 0);
         begin : t3_stall
            int n;
            n = 0;
            while (!out_if.TVALID && n < 50) begin
               @(negedge clk);
               n++;
            end
            if (n >= 50) fail_timeout("t3_first_out");
            @(posedge clk);
            #1;
            out_rdy = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("t3_in1_rdy_low", drv_rdy[1], 0);
               check("t3_grant_held", current_grant, 1);
            end
            @(posedge clk);
            #1;
            out_rdy = 1'b1;
         end
      join
      drain();

      // T4: body beat parked on in[3] is ignored; two back-to-back single-beat packets on in[0].
      set_beat(3, mk_beat(3, 8'hEE, 1, 4));
      repeat (3) begin
         @(negedge clk);
         check("t4_no_grant", grant_valid, 0);
         check("t4_in3_rdy", drv_rdy[3], 0);
      end
      @(posedge clk);
      #1;
      hs_cyc.delete();
      push_pkt(0, 5, 1);
      push_pkt(0, 6, 1);
      fork
         begin
            send_pkt(0, 5, 1, -1, 0);
            send_pkt(0, 6, 1, -1, 0);
         end
         begin
            @(negedge clk);
            @(negedge clk);
            check("t4_grant_valid", grant_valid, 1);
            check("t4_grant_idx", current_grant, 0);
            check("t4_in3_rdy_locked", drv_rdy[3], 0);
         end
      join
      drain();
      check("t4_pkt_spacing", (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1, 2);
      drv_vld[3] = 1'b0;

      // T5: granted in[2] drops TVALID mid-packet while in[0] waits.
      push_pkt(2, 7, 4);
      push_pkt(0, 7, 2);
      fork
         begin
            send_pkt(2, 7, 4, 1, 2);
            t5_done = 1'b1;
         end
         send_pkt(0, 7, 2, -1, 0);
         begin
            for (int n = 0; n < 60 && !t5_done; n++) begin
               @(negedge clk);
               if (grant_valid && !t5_done) begin
                  check("t5_grant_held", current_grant, 2);
                  check("t5_in0_rdy_low", drv_rdy[0], 0);
               end
            end
         end
      join
      drain();

      // T6: reset during the second beat of a 4-beat packet on in[3].
      out_rdy = 1'b0;
      set_beat(3, mk_beat(3, 8, 0, 4));
      wait_accept(3);
      set_beat(3, mk_beat(3, 8, 1, 4));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      drv_vld[3] = 1'b0;
      out_rdy    = 1'b1;
      @(negedge clk);
      check("t6_out_valid", out_if.TVALID, 0);
      check("t6_grant_valid", grant_valid, 0);
      check("t6_current_grant", current_grant, 0);
      check("t6_tready", drv_rdy, 0);
      @(posedge clk);
      #1;
      push_pkt(0, 9, 1);
      push_pkt(3, 9, 1);
      fork
         send_pkt(3, 9, 1, -1, 0);
         send_pkt(0, 9, 1, -1, 0);
         begin
            @(negedge clk);
            @(negedge clk);
            check("t6_regrant_idx", current_grant, 0);
         end
      join
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
